// File: rtl/tweak_schedule_if.sv
// Handshake/bus bundle between the tweak sequencer and its key-injection consumer.
interface tweak_schedule_if #(
    parameter int unsigned SIDX_W = 5
);
    logic              start_i;
    logic [191:0]      tweak_i;
    logic              next_i;
    logic              valid_o;
    logic [63:0]       ts0_o;
    logic [63:0]       ts1_o;
    logic [SIDX_W-1:0] sidx_o;
    logic              last_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;

    modport master (
        output start_i, tweak_i, next_i,
        input  valid_o, ts0_o, ts1_o, sidx_o, last_o, busy_o, done_o, err_o
    );

    modport slave (
        input  start_i, tweak_i, next_i,
        output valid_o, ts0_o, ts1_o, sidx_o, last_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/tweak_schedule.sv
// Skein-1024 per-subkey tweak sequencer: rotates (t0,t1,t2) once per accepted subkey.
// Optional tweak parity check enabled by defining TWEAK_SCHED_PARITY_CHECK_EN.
module tweak_schedule #(
    parameter int unsigned NUM_SUBKEYS = 21,
    parameter int unsigned SIDX_W      = 5
) (
    input logic             clk_i,
    input logic             rst_i,
    tweak_schedule_if.slave bus
);
    if ((1 << SIDX_W) < NUM_SUBKEYS) begin : g_bad_sidx_w
        $error("SIDX_W too narrow for NUM_SUBKEYS");
    end

    localparam logic [SIDX_W-1:0] LAST_IDX = SIDX_W'(NUM_SUBKEYS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [SIDX_W-1:0] s_q, s_d;
    logic [63:0]       ra_q, ra_d;
    logic [63:0]       rb_q, rb_d;
    logic [63:0]       rc_q, rc_d;
    logic              done_q, done_d;

    logic [63:0] t0, t1, t2;
    assign t0 = bus.tweak_i[63:0];
    assign t1 = bus.tweak_i[127:64];
    assign t2 = bus.tweak_i[191:128];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            s_q     <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rc_q    <= rc_d;
            done_q  <= done_d;
        end
    end

    // start_i takes priority over next_i, in either state.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rc_d    = rc_q;
        done_d  = 1'b0;
        if (bus.start_i) begin
            state_d = RUN;
            s_d     = '0;
            ra_d    = t0;
            rb_d    = t1;
            rc_d    = t2;
        end else if (state_q == RUN && bus.next_i) begin
            if (s_q == LAST_IDX) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                s_d  = s_q + 1'b1;
                ra_d = rb_q;
                rb_d = rc_q;
                rc_d = ra_q;
            end
        end
    end

`ifdef TWEAK_SCHED_PARITY_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (bus.start_i) begin
            err_d = (t2 != (t0 ^ t1));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err_o = err_q;
`else
    assign bus.err_o = 1'b0;
`endif

    assign bus.valid_o = (state_q == RUN);
    assign bus.busy_o  = (state_q == RUN);
    assign bus.ts0_o   = ra_q;
    assign bus.ts1_o   = rb_q;
    assign bus.sidx_o  = s_q;
    assign bus.last_o  = (state_q == RUN) && (s_q == LAST_IDX);
    assign bus.done_o  = done_q;
endmodule

// File: tb/tb_tweak_schedule.sv
// Directed self-checking bench for tweak_schedule; parity case active only with
// TWEAK_SCHED_PARITY_CHECK_EN defined.
module tb_tweak_schedule;
    localparam int unsigned NSK = 21;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    tweak_schedule_if #(.SIDX_W(5)) tsif ();

    tweak_schedule #(
        .NUM_SUBKEYS(NSK),
        .SIDX_W     (5)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (tsif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_err(input logic [63:0] t0, input logic [63:0] t1,
                                     input logic [63:0] t2);
`ifdef TWEAK_SCHED_PARITY_CHECK_EN
        return (t2 != (t0 ^ t1));
`else
        return 1'b0;
`endif
    endfunction

    // Walks subkeys s=0..20 with next_i held high, then checks the done pulse.
    task automatic run_tail(input logic [63:0] t0, input logic [63:0] t1,
                            input logic [63:0] t2, input logic e);
        logic [63:0] tw [3];
        tw[0] = t0;
        tw[1] = t1;
        tw[2] = t2;
        tsif.next_i = 1'b1;
        for (int s = 0; s < int'(NSK); s++) begin
            check("valid", 64'(tsif.valid_o), 64'd1);
            check("busy",  64'(tsif.busy_o),  64'd1);
            check("sidx",  64'(tsif.sidx_o),  64'(s));
            check("ts0",   tsif.ts0_o,        tw[s % 3]);
            check("ts1",   tsif.ts1_o,        tw[(s + 1) % 3]);
            check("last",  64'(tsif.last_o),  64'(s == int'(NSK) - 1));
            check("done_early", 64'(tsif.done_o), 64'd0);
            check("err",   64'(tsif.err_o),   64'(e));
            tick();
        end
        tsif.next_i = 1'b0;
        check("done_pulse", 64'(tsif.done_o),  64'd1);
        check("valid_end",  64'(tsif.valid_o), 64'd0);
        check("busy_end",   64'(tsif.busy_o),  64'd0);
        check("err_end",    64'(tsif.err_o),   64'(e));
    endtask

    task automatic start_block(input logic [63:0] t0, input logic [63:0] t1,
                               input logic [63:0] t2);
        tsif.start_i = 1'b1;
        tsif.tweak_i = {t2, t1, t0};
        tick();
        tsif.start_i = 1'b0;
    endtask

    task automatic run_block(input logic [63:0] t0, input logic [63:0] t1,
                             input logic [63:0] t2);
        start_block(t0, t1, t2);
        run_tail(t0, t1, t2, exp_err(t0, t1, t2));
    endtask

    initial begin
        logic [63:0] tw [3];
        int s;
        int cycles;
        logic nx;

        total = 0;
        bad   = 0;
        rst   = 1'b1;
        tsif.start_i = 1'b0;
        tsif.next_i  = 1'b0;
        tsif.tweak_i = '0;

        // Reset held two cycles.
        tick();
        tick();
        check("rst_valid", 64'(tsif.valid_o), 64'd0);
        check("rst_busy",  64'(tsif.busy_o),  64'd0);
        check("rst_done",  64'(tsif.done_o),  64'd0);
        check("rst_err",   64'(tsif.err_o),   64'd0);
        check("rst_ts0",   tsif.ts0_o,        64'd0);
        check("rst_ts1",   tsif.ts1_o,        64'd0);
        check("rst_sidx",  64'(tsif.sidx_o),  64'd0);
        rst = 1'b0;
        tick();

        // next_i in IDLE has no effect.
        tsif.next_i = 1'b1;
        tick();
        tsif.next_i = 1'b0;
        check("idle_next_valid", 64'(tsif.valid_o), 64'd0);

        // Message tweak, then a back-to-back block started on the done cycle.
        run_block(64'h40, 64'hF000000000000000, 64'hF000000000000040);
        run_block(64'h40, 64'hF000000000000000, 64'hF000000000000040);
        tick();
        check("done_one_cycle", 64'(tsif.done_o), 64'd0);

        // Output tweak with random next_i.
        tw[0] = 64'h8;
        tw[1] = 64'hFF00000000000000;
        tw[2] = 64'hFF00000000000008;
        start_block(tw[0], tw[1], tw[2]);
        s = 0;
        cycles = 0;
        while (s < int'(NSK) && cycles < 400) begin
            nx = 1'($urandom_range(0, 1));
            tsif.next_i = nx;
            check("rnd_valid", 64'(tsif.valid_o), 64'd1);
            check("rnd_sidx",  64'(tsif.sidx_o),  64'(s));
            check("rnd_ts0",   tsif.ts0_o,        tw[s % 3]);
            check("rnd_ts1",   tsif.ts1_o,        tw[(s + 1) % 3]);
            check("rnd_done",  64'(tsif.done_o),  64'd0);
            tick();
            if (nx) s++;
            cycles++;
        end
        tsif.next_i = 1'b0;
        check("rnd_finished", 64'(s), 64'(NSK));
        check("rnd_done_pulse", 64'(tsif.done_o), 64'd1);
        check("rnd_valid_end",  64'(tsif.valid_o), 64'd0);
        tick();

        // Restart at s=7: start_i beats next_i, no done_o.
        start_block(64'h1111, 64'h2222, 64'h3333);
        tsif.next_i = 1'b1;
        repeat (7) tick();
        check("pre_restart_sidx", 64'(tsif.sidx_o), 64'd7);
        tsif.start_i = 1'b1;
        tsif.tweak_i = {64'hC, 64'hB, 64'hA};
        tick();
        tsif.start_i = 1'b0;
        check("restart_ts0", tsif.ts0_o, 64'hA);
        run_tail(64'hA, 64'hB, 64'hC, exp_err(64'hA, 64'hB, 64'hC));
        tick();

        // Reset at s=12 aborts without done_o.
        start_block(64'h5, 64'h6, 64'h3);
        tsif.next_i = 1'b1;
        repeat (12) tick();
        check("pre_rst_sidx", 64'(tsif.sidx_o), 64'd12);
        rst = 1'b1;
        tsif.start_i = 1'b1;
        tick();
        rst = 1'b0;
        tsif.start_i = 1'b0;
        tsif.next_i = 1'b0;
        check("abort_valid", 64'(tsif.valid_o), 64'd0);
        check("abort_busy",  64'(tsif.busy_o),  64'd0);
        check("abort_done",  64'(tsif.done_o),  64'd0);
        check("abort_ts0",   tsif.ts0_o,        64'd0);
        check("abort_ts1",   tsif.ts1_o,        64'd0);
        check("abort_sidx",  64'(tsif.sidx_o),  64'd0);
        tick();
        check("abort_done2", 64'(tsif.done_o), 64'd0);
        run_block(64'h40, 64'hF000000000000000, 64'hF000000000000040);
        tick();

`ifdef TWEAK_SCHED_PARITY_CHECK_EN
        // Bad parity still issues all subkeys; a good tweak clears err_o.
        run_block(64'h0, 64'h0, 64'h1);
        tick();
        check("err_hold_idle", 64'(tsif.err_o), 64'd1);
        run_block(64'h8, 64'hFF00000000000000, 64'hFF00000000000008);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
